// File: rtl/scan_decoder.sv
// Binary-to-one-hot decoder with pulse/hold output modes and an ascending
// scan sweep across all outputs. Output register is one-hot or all-zero.
module scan_decoder #(
  parameter  int ADDR_WIDTH = 3,
  localparam int N          = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  addr_valid,
  output logic                  addr_ready,
  input  logic                  mode,
  input  logic                  scan_start,
  output logic [N-1:0]          out,
  output logic                  busy,
  output logic                  scan_done
);

  // state | meaning
  // IDLE  | accepting addresses or a scan request; out is pulse/held decode
  // SCAN  | sweeping out[0]..out[N-1], one per cycle; inputs ignored
  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t                state_q, state_nxt;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_nxt;
  logic [N-1:0]          out_q, out_nxt;
  logic                  hold_q, hold_nxt;
  logic                  done_q, done_nxt;

  function automatic logic [N-1:0] onehot(input logic [ADDR_WIDTH-1:0] a);
    logic [N-1:0] v;
    v    = '0;
    v[a] = 1'b1;
    return v;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      out_q   <= '0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      out_q   <= out_nxt;
      hold_q  <= hold_nxt;
      done_q  <= done_nxt;
    end
  end

  // Output defaults to zero each cycle; only a held decode or the scan
  // walker keeps a bit set, so at most one source ever drives out_nxt.
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    out_nxt   = '0;
    hold_nxt  = hold_q;
    done_nxt  = 1'b0;
    if (!enable) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      hold_nxt  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (addr_valid) begin
            out_nxt  = onehot(address);
            hold_nxt = mode;
          end else if (scan_start) begin
            state_nxt = SCAN;
            cnt_nxt   = '0;
            out_nxt   = onehot('0);
            hold_nxt  = 1'b0;
          end else if (hold_q) begin
            out_nxt = out_q;
          end
        end
        SCAN: begin
          // all-ones counter is the last scan output; leave before it wraps
          if (&cnt_q) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            done_nxt  = 1'b1;
          end else begin
            cnt_nxt = cnt_q + ADDR_WIDTH'(1);
            out_nxt = onehot(cnt_nxt);
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          hold_nxt  = 1'b0;
        end
      endcase
    end
  end

  assign addr_ready = (state_q == IDLE) && enable;
  assign out        = out_q;
  assign busy       = (state_q == SCAN);
  assign scan_done  = done_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Directed bench for scan_decoder (ADDR_WIDTH=3): the driver queues the
// expected post-edge response, a monitor pops and compares after each edge.
module tb_scan_decoder;

  localparam int AW = 3;
  localparam int N  = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [AW-1:0] address;
  logic          addr_valid;
  logic          addr_ready;
  logic          mode;
  logic          scan_start;
  logic [N-1:0]  out;
  logic          busy;
  logic          scan_done;

  int checks = 0;
  int errors = 0;
  int vec_id = 0;

  // expected = {out, busy, scan_done, addr_ready}
  logic [N+2:0] exp_q[$];
  int           id_q[$];

  scan_decoder #(.ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .address    (address),
    .addr_valid (addr_valid),
    .addr_ready (addr_ready),
    .mode       (mode),
    .scan_start (scan_start),
    .out        (out),
    .busy       (busy),
    .scan_done  (scan_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s vec %0d: got %0h expected %0h", name, id, act, req);
    end
  endtask

  // Apply inputs between edges and record what must be visible after the next edge.
  task automatic step(input logic en, input logic av, input logic [AW-1:0] a,
                      input logic md, input logic ss,
                      input logic [N-1:0] e_out, input logic e_busy,
                      input logic e_done, input logic e_ready);
    enable     = en;
    addr_valid = av;
    address    = a;
    mode       = md;
    scan_start = ss;
    exp_q.push_back({e_out, e_busy, e_done, e_ready});
    id_q.push_back(vec_id);
    vec_id++;
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    if (!reset) begin
      chk("onehot", vec_id, 32'($countones(out) <= 1), 32'd1);
      if (exp_q.size() != 0) begin
        logic [N+2:0] e;
        int           id;
        e  = exp_q.pop_front();
        id = id_q.pop_front();
        chk("out",        id, 32'(out),        32'(e[N+2:3]));
        chk("busy",       id, 32'(busy),       32'(e[2]));
        chk("scan_done",  id, 32'(scan_done),  32'(e[1]));
        chk("addr_ready", id, 32'(addr_ready), 32'(e[0]));
      end
    end
  end

  initial begin
    reset      = 1'b1;
    enable     = 1'b1;
    addr_valid = 1'b0;
    address    = 'x;
    mode       = 1'b0;
    scan_start = 1'b0;
    #2;
    chk("rst_out",  -1, 32'(out),       32'd0);
    chk("rst_busy", -1, 32'(busy),      32'd0);
    chk("rst_done", -1, 32'(scan_done), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // back-to-back hold-mode accepts, first one on the first edge after reset
    for (int i = 0; i < N; i++)
      step(1, 1, AW'(i), 1, 0, N'(1) << i, 0, 0, 1);
    step(1, 0, 'x, 0, 0, 8'h80, 0, 0, 1);
    step(1, 0, 'x, 1, 0, 8'h80, 0, 0, 1);

    // pulse mode, single and back-to-back
    step(1, 1, 3'd5, 0, 0, 8'h20, 0, 0, 1);
    step(1, 0, 'x,   0, 0, 8'h00, 0, 0, 1);
    step(1, 1, 3'd1, 0, 0, 8'h02, 0, 0, 1);
    step(1, 1, 3'd3, 0, 0, 8'h08, 0, 0, 1);
    step(1, 0, 'x,   0, 0, 8'h00, 0, 0, 1);

    // disabled: nothing accepted
    for (int i = 0; i < N; i++)
      step(0, 1, AW'(i), 1, 0, 8'h00, 0, 0, 0);

    // held output cleared by enable drop
    step(1, 1, 3'd3, 1, 0, 8'h08, 0, 0, 1);
    step(1, 0, 'x,   0, 0, 8'h08, 0, 0, 1);
    step(0, 0, 'x,   0, 0, 8'h00, 0, 0, 0);
    step(1, 0, 'x,   0, 0, 8'h00, 0, 0, 1);

    // full scan from a held output; addresses/scan_start ignored while busy
    step(1, 1, 3'd6, 1, 0, 8'h40, 0, 0, 1);
    step(1, 0, 'x,   0, 1, 8'h01, 1, 0, 0);
    step(1, 1, 3'd6, 1, 1, 8'h02, 1, 0, 0);
    step(1, 0, 'x,   0, 0, 8'h04, 1, 0, 0);
    step(1, 1, 3'd0, 0, 0, 8'h08, 1, 0, 0);
    step(1, 0, 'x,   0, 1, 8'h10, 1, 0, 0);
    step(1, 0, 'x,   0, 0, 8'h20, 1, 0, 0);
    step(1, 0, 'x,   0, 0, 8'h40, 1, 0, 0);
    step(1, 0, 'x,   0, 0, 8'h80, 1, 0, 0);
    step(1, 1, 3'd2, 1, 1, 8'h00, 0, 1, 1);
    // accept on the scan_done cycle
    step(1, 1, 3'd4, 0, 0, 8'h10, 0, 0, 1);
    step(1, 0, 'x,   0, 0, 8'h00, 0, 0, 1);

    // address beats scan_start, no scan queued
    step(1, 1, 3'd2, 0, 1, 8'h04, 0, 0, 1);
    step(1, 0, 'x,   0, 0, 8'h00, 0, 0, 1);
    step(1, 0, 'x,   0, 0, 8'h00, 0, 0, 1);

    // enable drop in the 4th scan cycle
    step(1, 0, 'x, 0, 1, 8'h01, 1, 0, 0);
    step(1, 0, 'x, 0, 0, 8'h02, 1, 0, 0);
    step(1, 0, 'x, 0, 0, 8'h04, 1, 0, 0);
    step(1, 0, 'x, 0, 0, 8'h08, 1, 0, 0);
    step(0, 0, 'x, 0, 0, 8'h00, 0, 0, 0);
    step(1, 0, 'x, 0, 0, 8'h00, 0, 0, 1);
    step(1, 0, 'x, 0, 0, 8'h00, 0, 0, 1);

    // asynchronous reset in the 3rd scan cycle
    step(1, 0, 'x, 0, 1, 8'h01, 1, 0, 0);
    step(1, 0, 'x, 0, 0, 8'h02, 1, 0, 0);
    step(1, 0, 'x, 0, 0, 8'h04, 1, 0, 0);
    reset = 1'b1;
    #1;
    chk("arst_out",  -2, 32'(out),       32'd0);
    chk("arst_busy", -2, 32'(busy),      32'd0);
    chk("arst_done", -2, 32'(scan_done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    step(1, 1, 3'd7, 1, 0, 8'h80, 0, 0, 1);
    step(1, 0, 'x,   0, 0, 8'h80, 0, 0, 1);
    step(1, 0, 'x,   0, 0, 8'h80, 0, 0, 1);

    chk("queue_drained", -3, 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/scan_decoder.md
SCAN_DECODER -- requirements
Module: scan_decoder

Interface
REQ-001 Parameter: ADDR_WIDTH, default 3, address width; output width is N = 2**ADDR_WIDTH, with ADDR_WIDTH from 1 to 8.
REQ-002 Port: clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: enable  input  1  global gate; while low, no address or scan is accepted.
REQ-005 Port: address  input  ADDR_WIDTH  binary select; bit 0 is LSB.
REQ-006 Port: addr_valid  input  1  address is presented for decode.
REQ-007 Port: addr_ready  output  1  block accepts an address this cycle.
REQ-008 Port: mode  input  1  0 = pulse, 1 = hold; sampled only at address acceptance.
REQ-009 Port: scan_start  input  1  request to sweep all N outputs in turn.
REQ-010 Port: out  output  N  registered one-hot or all-zero decode; out[k] corresponds to code k.
REQ-011 Port: busy  output  1  a scan is in progress.
REQ-012 Port: scan_done  output  1  one-cycle pulse on the cycle after the final scan output.

Function
REQ-013 The block SHALL have two states: IDLE and SCAN.
REQ-014 addr_ready SHALL equal (state==IDLE) AND enable, combinationally.
REQ-015 An address is accepted on a rising edge where addr_valid and addr_ready are both 1.
REQ-016 Out SHALL show one-hot(address) on the edge that accepts the address, giving 1-cycle latency.
REQ-017 Pulse mode: out SHALL return to all-zero on the next edge unless another address is accepted on that edge.
REQ-018 Hold mode: out SHALL hold its value until the next accepted address, a scan start, enable low at an edge, or reset.
REQ-019 Back-to-back accepts SHALL be allowed, one per cycle, with no bubble between them.
REQ-020 In IDLE, enable=1, scan_start=1 and no address accepted: on that edge the block SHALL enter SCAN with counter=0, out=one-hot(0) and busy=1.
REQ-021 In IDLE with addr_valid=1 and scan_start=1 on the same edge, the address SHALL win and scan_start SHALL be ignored, not queued.
REQ-022 In SCAN: on each edge the counter SHALL increment and out SHALL equal one-hot(counter), so out[0]..out[N-1] are each high for exactly one cycle, in ascending order.
REQ-023 At the edge after out[N-1], the block SHALL go to IDLE with out=0, busy=0 and scan_done=1 for exactly one cycle.
REQ-024 The counter SHALL be ADDR_WIDTH bits wide and SHALL NOT wrap inside a scan.
REQ-025 A scan is N cycles busy, and the earliest next accept is on the scan_done cycle.
REQ-026 scan_start, addr_valid and mode SHALL be ignored while in SCAN.
REQ-027 While in SCAN, addr_ready SHALL be 0.
REQ-028 enable low at any edge SHALL force out=0 and state=IDLE on that edge, aborting any scan, with busy=0 and no scan_done pulse.
REQ-029 out SHALL always be one-hot or all-zero.
REQ-030 out SHALL never have two bits set, including during mode or state transitions.
REQ-031 X/Z on address while addr_valid=0 SHALL NOT affect out.

Reset
REQ-032 Asserting reset SHALL immediately, with no clock needed, set state=IDLE, counter=0, out=0, busy=0 and scan_done=0.
REQ-033 Reset mid-scan SHALL abort the scan with no scan_done pulse.
REQ-034 After reset is released, the first accept SHALL be possible on the first rising edge.

Verification (ADDR_WIDTH=3)
REQ-035 Exhaustive accept: enable=1, mode=1, addresses 0..7 accepted back-to-back -> out = 00000001, 00000010, ... 10000000, one per cycle; out holds 10000000 afterwards.
REQ-036 Pulse mode: enable=1, mode=0, address=5 accepted once -> out=00100000 for one cycle, then 00000000.
REQ-037 Disable: enable=0, addr_valid=1 for all 8 addresses -> addr_ready=0 and out=0 throughout.
REQ-038 Disable with held output: mode=1 holding 00001000, then enable drops -> out=0 on the next edge.
REQ-039 Scan: scan_start for one cycle -> busy=1 for 8 cycles, out walks 00000001 to 10000000, then scan_done=1 for one cycle with out=0 and addr_ready=1.
REQ-040 Conflict and abort: addr_valid=1, address=2 and scan_start=1 together -> out=00000100 and no scan starts.
REQ-041 Enable drop mid-scan: scan started, enable=0 at the 4th scan cycle -> out=0, busy=0, no scan_done pulse.
REQ-042 Reset mid-scan: scan started, reset asserted asynchronously at the 3rd scan cycle -> out=0 and busy=0 immediately; first post-reset accept of address 7 -> out=10000000.
